// File: rtl/pc_pkg.sv
// Shared types and constants for the MIPS next-PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {RUN, PEND, TRAP} pc_state_t;
  typedef enum logic [1:0] {SEQ, BR, JMP, JR} redir_sel_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/next_pc_target.sv
// Combinational target generation: branch, jump and register-jump targets plus misalign flag.
module next_pc_target
  import pc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 26
) (
  input  logic [ADDR_W-1:0]  i_pc_plus4,
  input  logic [INDEX_W-1:0] i_instr_index,
  input  logic [15:0]        i_branch_off,
  input  logic [ADDR_W-1:0]  i_jr_target,
  output logic [ADDR_W-1:0]  o_br_tgt,
  output logic [ADDR_W-1:0]  o_jmp_tgt,
  output logic [ADDR_W-1:0]  o_jr_tgt,
  output logic               o_misalign
);

  logic [ADDR_W-1:0] w_off_sext;

  assign w_off_sext = ADDR_W'($signed(i_branch_off));
  assign o_br_tgt   = i_pc_plus4 + (w_off_sext << 2);
  assign o_jmp_tgt  = {i_pc_plus4[ADDR_W-1:INDEX_W+2], i_instr_index, 2'b00};
  // Low bits always cleared; only matters while trapped, since a misaligned
  // jr outside TRAP never becomes a redirect.
  assign o_jr_tgt   = {i_jr_target[ADDR_W-1:2], ~ALIGN_MASK & i_jr_target[1:0]};
  assign o_misalign = is_misaligned(i_jr_target[1:0]);

endmodule

// File: rtl/next_pc_unit.sv
// PC register and next-PC FSM (RUN / PEND / TRAP) with optional branch delay slot.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W                = 32,
  parameter int INDEX_W               = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h8000_0180),
  parameter bit DELAY_SLOT            = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jump,
  input  logic               jal,
  input  logic               jr,
  input  logic               branch_taken,
  input  logic [INDEX_W-1:0] instr_index,
  input  logic [15:0]        branch_off,
  input  logic [ADDR_W-1:0]  jr_target,
  input  logic               trap_ack,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               misaligned_trap,
  output logic [ADDR_W-1:0]  bad_addr
);

  pc_state_t         r_state, w_state_nxt;
  redir_sel_t        w_sel;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_tgt, w_tgt_nxt;
  logic [ADDR_W-1:0] r_bad, w_bad_nxt;
  logic [ADDR_W-1:0] w_pc_plus4, w_sel_tgt;
  logic [ADDR_W-1:0] w_br_tgt, w_jmp_tgt, w_jr_tgt;
  logic              w_misalign, w_jr_trap;
  logic              w_unused;

  // jal only qualifies link_addr downstream; the return address itself is pc-derived.
  assign w_unused   = jal;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  next_pc_target #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) u_tgt (
    .i_pc_plus4   (w_pc_plus4),
    .i_instr_index(instr_index),
    .i_branch_off (branch_off),
    .i_jr_target  (jr_target),
    .o_br_tgt     (w_br_tgt),
    .o_jmp_tgt    (w_jmp_tgt),
    .o_jr_tgt     (w_jr_tgt),
    .o_misalign   (w_misalign)
  );

  always_comb begin
    w_sel = SEQ;
    if (jr)                w_sel = JR;
    else if (jump)         w_sel = JMP;
    else if (branch_taken) w_sel = BR;
  end

  always_comb begin
    w_sel_tgt = w_pc_plus4;
    case (w_sel)
      JR:      w_sel_tgt = w_jr_tgt;
      JMP:     w_sel_tgt = w_jmp_tgt;
      BR:      w_sel_tgt = w_br_tgt;
      default: w_sel_tgt = w_pc_plus4;
    endcase
  end

  assign w_jr_trap = jr && w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_VEC;
      r_tgt   <= '0;
      r_bad   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_bad_nxt   = r_bad;
    if (!stall) begin
      case (r_state)
        RUN: begin
          if (w_jr_trap) begin
            w_pc_nxt    = EXC_VEC;
            w_bad_nxt   = jr_target;
            w_tgt_nxt   = '0;
            w_state_nxt = TRAP;
          end else if (w_sel != SEQ) begin
            if (DELAY_SLOT) begin
              w_tgt_nxt   = w_sel_tgt;
              w_pc_nxt    = w_pc_plus4;
              w_state_nxt = PEND;
            end else begin
              w_pc_nxt = w_sel_tgt;
            end
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
        PEND: begin
          // Redirects in the slot are dropped; only a misaligned jr still traps.
          if (w_jr_trap) begin
            w_pc_nxt    = EXC_VEC;
            w_bad_nxt   = jr_target;
            w_tgt_nxt   = '0;
            w_state_nxt = TRAP;
          end else begin
            w_pc_nxt    = r_tgt;
            w_state_nxt = RUN;
          end
        end
        TRAP: begin
          w_pc_nxt = w_sel_tgt;
          if (trap_ack) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    pc              = r_pc;
    pc_plus4        = w_pc_plus4;
    link_addr       = r_pc + ADDR_W'(DELAY_SLOT ? 8 : 4);
    misaligned_trap = (r_state == TRAP);
    bad_addr        = r_bad;
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed check of next_pc_unit: instance a without delay slot, instance b with delay slot.
module tb_next_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_rst_n, a_stall, a_jump, a_jal, a_jr, a_br, a_ack;
  logic [25:0] a_idx;
  logic [15:0] a_off;
  logic [31:0] a_jrt, a_pc, a_pc4, a_link, a_bad;
  logic        a_trap;

  logic        b_rst_n, b_stall, b_jump, b_jal, b_jr, b_br, b_ack;
  logic [25:0] b_idx;
  logic [15:0] b_off;
  logic [31:0] b_jrt, b_pc, b_pc4, b_link, b_bad;
  logic        b_trap;

  next_pc_unit #(.DELAY_SLOT(1'b0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .stall(a_stall), .jump(a_jump), .jal(a_jal),
    .jr(a_jr), .branch_taken(a_br), .instr_index(a_idx), .branch_off(a_off),
    .jr_target(a_jrt), .trap_ack(a_ack), .pc(a_pc), .pc_plus4(a_pc4),
    .link_addr(a_link), .misaligned_trap(a_trap), .bad_addr(a_bad)
  );

  next_pc_unit #(.DELAY_SLOT(1'b1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .stall(b_stall), .jump(b_jump), .jal(b_jal),
    .jr(b_jr), .branch_taken(b_br), .instr_index(b_idx), .branch_off(b_off),
    .jr_target(b_jrt), .trap_ack(b_ack), .pc(b_pc), .pc_plus4(b_pc4),
    .link_addr(b_link), .misaligned_trap(b_trap), .bad_addr(b_bad)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_stall = 0; a_jump = 0; a_jal = 0; a_jr = 0; a_br = 0; a_ack = 0;
    a_idx = '0; a_off = '0; a_jrt = '0;
  endtask

  task automatic b_idle();
    b_stall = 0; b_jump = 0; b_jal = 0; b_jr = 0; b_br = 0; b_ack = 0;
    b_idx = '0; b_off = '0; b_jrt = '0;
  endtask

  initial begin
    a_idle(); b_idle();
    a_rst_n = 0; b_rst_n = 0;
    #3;
    chk("a_rst_pc", a_pc, 32'h0);
    chk("a_rst_trap", {31'b0, a_trap}, 32'h0);
    chk("a_rst_bad", a_bad, 32'h0);
    tick(); a_rst_n = 1;
    chk("a_free0", a_pc, 32'h0);
    tick(); chk("a_free1", a_pc, 32'h4);
    tick(); chk("a_free2", a_pc, 32'h8);
    tick(); chk("a_free3", a_pc, 32'hC);
    chk("a_free_trap", {31'b0, a_trap}, 32'h0);

    a_jump = 1; a_idx = 26'h0100004; tick(); a_idle();
    chk("a_jmp_setup", a_pc, 32'h0040_0010);
    chk("a_pc4", a_pc4, 32'h0040_0014);
    chk("a_link", a_link, 32'h0040_0014);
    a_jump = 1; a_idx = 26'h0100000; tick(); a_idle();
    chk("a_jmp", a_pc, 32'h0040_0000);
    a_jump = 1; a_idx = 26'h0100004; tick(); a_idle();
    chk("a_jmp_back", a_pc, 32'h0040_0010);
    a_br = 1; a_off = 16'hFFFE; tick(); a_idle();
    chk("a_br_neg", a_pc, 32'h0040_000C);

    a_jr = 1; a_jrt = 32'h200; a_jump = 1; a_idx = 26'h5; a_br = 1; a_off = 16'h4;
    tick(); a_idle();
    chk("a_prio_jr", a_pc, 32'h200);
    a_jump = 1; a_idx = 26'h40; a_br = 1; a_off = 16'h4; tick(); a_idle();
    chk("a_prio_jmp", a_pc, 32'h100);

    a_stall = 1; a_jump = 1; a_idx = 26'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_stall", a_pc, 32'h100);
    end
    a_idle(); tick();
    chk("a_unstall", a_pc, 32'h104);

    a_jr = 1; a_jrt = 32'h102; tick(); a_idle();
    chk("a_trap_pc", a_pc, 32'h8000_0180);
    chk("a_trap_on", {31'b0, a_trap}, 32'h1);
    chk("a_trap_bad", a_bad, 32'h102);
    tick();
    chk("a_trap_seq", a_pc, 32'h8000_0184);
    chk("a_trap_hold", {31'b0, a_trap}, 32'h1);
    a_jr = 1; a_jrt = 32'h307; tick(); a_idle();
    chk("a_trap_force", a_pc, 32'h304);
    chk("a_trap_bad2", a_bad, 32'h102);
    a_stall = 1; a_ack = 1; tick(); a_idle();
    chk("a_ack_stall_pc", a_pc, 32'h304);
    chk("a_ack_stall", {31'b0, a_trap}, 32'h1);
    a_ack = 1; tick(); a_idle();
    chk("a_ack_pc", a_pc, 32'h308);
    chk("a_ack_exit", {31'b0, a_trap}, 32'h0);

    a_jr = 1; a_jrt = 32'hFFFF_FFFC; tick(); a_idle();
    chk("a_wrap_pre", a_pc, 32'hFFFF_FFFC);
    chk("a_wrap_pc4", a_pc4, 32'h0);
    tick();
    chk("a_wrap", a_pc, 32'h0);
    chk("a_wrap_notrap", {31'b0, a_trap}, 32'h0);

    tick(); b_rst_n = 1;
    repeat (8) tick();
    chk("b_seq", b_pc, 32'h20);
    chk("b_link", b_link, 32'h28);
    b_jr = 1; b_jrt = 32'h100; tick(); b_idle();
    chk("b_slot", b_pc, 32'h24);
    b_br = 1; b_off = 16'h10; tick(); b_idle();
    chk("b_redir", b_pc, 32'h100);
    chk("b_link2", b_link, 32'h108);
    tick();
    chk("b_after", b_pc, 32'h104);

    b_jump = 1; b_idx = 26'h40; tick(); b_idle();
    chk("b_slot2", b_pc, 32'h108);
    b_jr = 1; b_jrt = 32'h1FE; tick(); b_idle();
    chk("b_slot_trap_pc", b_pc, 32'h8000_0180);
    chk("b_slot_trap", {31'b0, b_trap}, 32'h1);
    chk("b_slot_bad", b_bad, 32'h1FE);
    b_jump = 1; b_idx = 26'h40; b_ack = 1; tick(); b_idle();
    chk("b_trap_jmp", b_pc, 32'h8000_0100);
    chk("b_trap_exit", {31'b0, b_trap}, 32'h0);

    b_jump = 1; b_idx = 26'h80; tick(); b_idle();
    chk("b_pend_rst_pre", b_pc, 32'h8000_0104);
    #2 b_rst_n = 0;
    #1 chk("b_pend_rst", b_pc, 32'h0);
    #1 b_rst_n = 1;
    tick();
    chk("b_rst_noredir1", b_pc, 32'h4);
    tick();
    chk("b_rst_noredir2", b_pc, 32'h8);

    b_jump = 1; b_idx = 26'h40; tick(); b_idle();
    chk("b_stall_pend0", b_pc, 32'hC);
    b_stall = 1; b_br = 1; b_off = 16'h20;
    tick(); chk("b_stall_pend1", b_pc, 32'hC);
    tick(); chk("b_stall_pend2", b_pc, 32'hC);
    b_idle(); tick();
    chk("b_stall_pend_done", b_pc, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
